// File: rtl/dlx_io_pkg.sv
// Shared definitions for the DLX I/O space: address map, read-word layout and access decode.
package dlx_io_pkg;

  localparam int unsigned IO_ADDR_SWITCHES = 0;
  localparam int unsigned IO_ADDR_KEYS     = 1;
  localparam int unsigned IO_ADDR_LED      = 2;
  localparam int unsigned IO_ADDR_7SEG_LO  = 3;
  localparam int unsigned IO_ADDR_7SEG_HI  = 7;

  // Bit position of the sticky press flags in the keys read word.
  localparam int unsigned KEY_FLAG_LSB = 16;

  typedef enum logic [1:0] {
    RdNone,
    RdSwitches,
    RdKeys
  } rd_sel_e;

  // Switch select wins if the decoder ever raises both selects.
  function automatic rd_sel_e decode_access(input logic rd_en,
                                            input logic cs_switches,
                                            input logic cs_keys);
    rd_sel_e sel;
    sel = RdNone;
    if (rd_en) begin
      if (cs_switches) begin
        sel = RdSwitches;
      end else if (cs_keys) begin
        sel = RdKeys;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit input conditioner: 2-flop synchronizer followed by a stable-count debouncer.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Counter only runs while the synced level disagrees; it is cleared on accept, so it never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped switch/key input peripheral: debounced levels, sticky press flags with
// read-to-clear, and a registered 1-cycle read response.
module io_input_ctrl
  import dlx_io_pkg::*;
#(
  parameter int unsigned N_SW            = 10,
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [N_KEYS-1:0] key_n_in,
  input  logic              cs_switches,
  input  logic              cs_keys,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              key_irq
);

  // Presses are ignored until a key held through reset has had time to debounce to "down",
  // so that it is only reported after a release and a fresh press.
  localparam int unsigned        SettleCycles = DEBOUNCE_CYCLES + 4;
  localparam int unsigned        SettleW      = $clog2(SettleCycles + 1);
  localparam logic [SettleW-1:0] SettleDone   = SettleW'(SettleCycles);

  logic [N_SW-1:0]    sw_stable;
  logic [N_KEYS-1:0]  key_stable;
  logic [N_KEYS-1:0]  key_down;
  logic [N_KEYS-1:0]  key_down_q;
  logic [N_KEYS-1:0]  press;
  logic [N_KEYS-1:0]  flag_q;
  logic [N_KEYS-1:0]  flag_d;
  logic [SettleW-1:0] settle_q;
  logic [SettleW-1:0] settle_d;
  logic               armed;
  rd_sel_e            rd_sel;
  logic [31:0]        rd_data_q;
  logic [31:0]        rd_data_d;
  logic               rd_valid_q;
  logic               key_irq_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (sw_in[i]),
      .stable_o(sw_stable[i])
    );
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (key_n_in[i]),
      .stable_o(key_stable[i])
    );
  end

  assign key_down = ~key_stable;
  assign armed    = (settle_q == SettleDone);
  assign press    = key_down & ~key_down_q & {N_KEYS{armed}};

  always_comb begin
    rd_sel    = decode_access(rd_en, cs_switches, cs_keys);
    rd_data_d = '0;
    settle_d  = armed ? settle_q : settle_q + SettleW'(1);
    case (rd_sel)
      RdSwitches: rd_data_d[N_SW-1:0] = sw_stable;
      RdKeys: begin
        rd_data_d[N_KEYS-1:0]              = key_down;
        rd_data_d[KEY_FLAG_LSB +: N_KEYS]  = flag_q;
      end
      default: ;
    endcase
    // A press in the clearing cycle survives the clear.
    flag_d = ((rd_sel == RdKeys) ? '0 : flag_q) | press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_down_q <= '0;
      flag_q     <= '0;
      settle_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      key_irq_q  <= 1'b0;
    end else begin
      key_down_q <= key_down;
      flag_q     <= flag_d;
      settle_q   <= settle_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= (rd_sel != RdNone);
      key_irq_q  <= |flag_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign key_irq  = key_irq_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: directed scenarios plus random input/read traffic,
// checked against a window-based behavioural model of the debounce and flag rules.
module tb_io_input_ctrl;

  localparam int N_SW   = 10;
  localparam int N_KEYS = 4;
  localparam int DB     = 4;
  localparam int NB     = N_SW + N_KEYS;
  localparam logic [NB-1:0] RawRst = {{N_KEYS{1'b1}}, {N_SW{1'b0}}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_SW-1:0]   sw_in;
  logic [N_KEYS-1:0] key_n_in;
  logic              cs_switches;
  logic              cs_keys;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              key_irq;

  always #5 clk = ~clk;

  io_input_ctrl #(
    .N_SW           (N_SW),
    .N_KEYS         (N_KEYS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .key_n_in   (key_n_in),
    .cs_switches(cs_switches),
    .cs_keys    (cs_keys),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .key_irq    (key_irq)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_resp   = 0;
  logic [31:0] last_rd  = '0;
  logic [31:0] exp_q[$];

  // Reference model state: raw sample history, accepted levels, press flags.
  logic [NB-1:0]     hist[$];
  logic [NB-1:0]     stable_m;
  logic [N_KEYS-1:0] kd_prev_m;
  logic [N_KEYS-1:0] flags_m;
  logic              irq_m;
  int                edges_m;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < DB + 1; j++) hist.push_back(RawRst);
    stable_m  = RawRst;
    kd_prev_m = '0;
    flags_m   = '0;
    irq_m     = 1'b0;
    edges_m   = 0;
    exp_q.delete();
  endtask

  // One clock edge of behaviour, evaluated on the state seen just before the edge.
  task automatic model_step();
    logic [N_KEYS-1:0] kd;
    logic [N_KEYS-1:0] press;
    logic [NB-1:0]     flip;
    logic [31:0]       w;
    kd = ~stable_m[NB-1:N_SW];
    if (rd_en && (cs_switches || cs_keys)) begin
      if (cs_switches) w = 32'(stable_m[N_SW-1:0]);
      else             w = 32'(kd) | (32'(flags_m) << 16);
      exp_q.push_back(w);
    end
    // A key already down when the inputs settle after reset is not a press.
    press = (edges_m >= DB + 4) ? (kd & ~kd_prev_m) : '0;
    irq_m = |flags_m;
    if (rd_en && cs_keys && !cs_switches) flags_m = press;
    else                                  flags_m = flags_m | press;
    kd_prev_m = kd;
    // hist[0..DB-1] are the synced levels seen at the last DB edges; all differing accepts.
    flip = '1;
    for (int j = 0; j < DB; j++) flip &= hist[j] ^ stable_m;
    stable_m ^= flip;
    hist.push_back({key_n_in, sw_in});
    void'(hist.pop_front());
    if (edges_m < 1000) edges_m++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: compares every response and the idle/irq outputs away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check32("reset rd_data", rd_data, 32'h0);
        check32("reset rd_valid", 32'(rd_valid), 32'h0);
        check32("reset key_irq", 32'(key_irq), 32'h0);
      end else begin
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious rd_valid: got data %h, expected no response", rd_data);
          end else begin
            check32("rd_data", rd_data, exp_q.pop_front());
          end
          last_rd = rd_data;
          n_resp++;
        end else begin
          if (exp_q.size() != 0) begin
            check32("rd_valid missing", 32'(rd_valid), 32'h1);
            void'(exp_q.pop_front());
          end
          check32("idle rd_data", rd_data, 32'h0);
        end
        check32("key_irq", 32'(key_irq), 32'(irq_m));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic sw, input logic k);
    rd_en       = 1'b1;
    cs_switches = sw;
    cs_keys     = k;
    @(negedge clk);
    rd_en       = 1'b0;
    cs_switches = 1'b0;
    cs_keys     = 1'b0;
    #1;
  endtask

  initial begin
    int r0;
    int b;
    int sel;
    rst_n       = 1'b0;
    sw_in       = '0;
    key_n_in    = '1;
    rd_en       = 1'b0;
    cs_switches = 1'b0;
    cs_keys     = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    #1;
    check32("post-reset rd_data", rd_data, 32'h0);
    check32("post-reset rd_valid", 32'(rd_valid), 32'h0);
    check32("post-reset key_irq", 32'(key_irq), 32'h0);
    cyc(12);

    // Switches: early read sees the old level, later read the debounced pattern.
    sw_in = 10'h2A5;
    cyc(2);
    rd(1'b1, 1'b0);
    check32("switches before debounce", last_rd, 32'h0);
    cyc(8);
    rd(1'b1, 1'b0);
    check32("switches debounced", last_rd, 32'h0000_02A5);

    // Short glitch on key 1 is rejected.
    key_n_in[1] = 1'b0;
    cyc(3);
    key_n_in[1] = 1'b1;
    cyc(10);
    rd(1'b0, 1'b1);
    check32("glitch keys word", last_rd, 32'h0);
    check32("glitch key_irq", 32'(key_irq), 32'h0);

    // Key 2 held, read during hold, read after release.
    key_n_in[2] = 1'b0;
    cyc(8);
    check32("hold key_irq", 32'(key_irq), 32'h1);
    rd(1'b0, 1'b1);
    check32("key2 held word", last_rd, 32'h0004_0004);
    key_n_in[2] = 1'b1;
    cyc(8);
    rd(1'b0, 1'b1);
    check32("key2 released word", last_rd, 32'h0);
    check32("released key_irq", 32'(key_irq), 32'h0);

    // Press landing on the same edge as the clearing read survives the clear.
    key_n_in[0] = 1'b0;
    cyc(10);
    rd(1'b0, 1'b1);
    check32("key0 first press", last_rd, 32'h0001_0001);
    key_n_in[0] = 1'b1;
    cyc(10);
    key_n_in[0] = 1'b0;
    cyc(6);
    rd(1'b0, 1'b1);
    check32("read racing press", last_rd, 32'h0000_0001);
    rd(1'b0, 1'b1);
    check32("flag kept after race", last_rd, 32'h0001_0001);
    key_n_in[0] = 1'b1;
    cyc(10);

    // No-select read gives nothing; double select returns the switch word.
    r0 = n_resp;
    rd(1'b0, 1'b0);
    check32("no-select response count", 32'(n_resp), 32'(r0));
    rd(1'b1, 1'b1);
    check32("both-select word", last_rd, 32'h0000_02A5);
    check32("both-select response count", 32'(n_resp), 32'(r0 + 1));

    // Reset during a pending read, with key 3 held through reset.
    key_n_in[3] = 1'b0;
    cyc(2);
    rd_en       = 1'b1;
    cs_switches = 1'b1;
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    rd_en       = 1'b0;
    cs_switches = 1'b0;
    #1;
    check32("async reset rd_valid", 32'(rd_valid), 32'h0);
    check32("async reset rd_data", rd_data, 32'h0);
    check32("async reset key_irq", 32'(key_irq), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(15);
    rd(1'b0, 1'b1);
    check32("held-through-reset word", last_rd, 32'h0000_0008);
    check32("held-through-reset irq", 32'(key_irq), 32'h0);
    key_n_in[3] = 1'b1;
    cyc(10);
    key_n_in[3] = 1'b0;
    cyc(10);
    rd(1'b0, 1'b1);
    check32("key3 fresh press", last_rd, 32'h0008_0008);
    key_n_in[3] = 1'b1;
    cyc(10);

    // Random input toggles (including glitches) with random read traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        b = $urandom_range(0, N_SW - 1);
        sw_in[b] = ~sw_in[b];
      end
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, N_KEYS - 1);
        key_n_in[b] = ~key_n_in[b];
      end
      sel         = $urandom_range(0, 9);
      rd_en       = (sel >= 3);
      cs_switches = (sel == 4 || sel == 5 || sel == 9);
      cs_keys     = (sel >= 6);
      @(negedge clk);
    end
    rd_en       = 1'b0;
    cs_switches = 1'b0;
    cs_keys     = 1'b0;
    cyc(3);
    check32("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
# io_input_ctrl

Memory-mapped input peripheral for the DLX pipeline's I/O space, the downstream consumer of the chip-select decoder's `cs_switches` (address 0) and `cs_keys` (address 1) strobes. Synchronizes and debounces raw board switches and push-buttons, and latches key-press events in sticky flags. Returns a registered 32-bit read word to the MEM stage's load path.

## Interface
- `N_SW`, 10, number of slide switches (1..16)
- `N_KEYS`, 4, number of push-buttons (1..16)
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept an input change (≥2)
- `clk`  in  1  system clock; the block's only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `sw_in`  in  N_SW  raw switch levels, asynchronous to clk, 1 = on
- `key_n_in`  in  N_KEYS  raw button levels, asynchronous to clk, active-low (0 = pressed)
- `cs_switches`  in  1  decoder select for address 0
- `cs_keys`  in  1  decoder select for address 1
- `rd_en`  in  1  load strobe from the MEM stage, 1 cycle per access
- `rd_data`  out  32  registered read word
- `rd_valid`  out  1  1-cycle pulse; `rd_data` is valid in that cycle
- `key_irq`  out  1  registered OR of all sticky press flags

## Operation
- Per input bit: 2-flop synchronizer, then debouncer holding a `stable` value and a counter.
- Counter rule: if synced ≠ stable, counter += 1; if synced = stable, counter ← 0. When the counter is DEBOUNCE_CYCLES−1 and synced still ≠ stable, stable ← synced and counter ← 0. A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps.
- Key level is inverted after debounce: `key_down[i]` = ~stable_key[i].
- Press event: `key_down[i]` 0→1 sets `press_flag[i]`. Release sets nothing.
- Read word, switches: bits [N_SW-1:0] = debounced switches; all other bits 0.
- Read word, keys: bits [N_KEYS-1:0] = `key_down`; bits [16+N_KEYS-1:16] = `press_flag`; all other bits 0.
- An access is `rd_en & (cs_switches | cs_keys)`. If both selects are high, the switch read wins; the decoder never produces this.
- Read-to-clear: an accepted keys read clears all `press_flag` bits that were returned. A press event in the same cycle as the clear wins: that flag stays set and the next read returns it.
- Writes do not exist; the block has no write port. Stores to addresses 0/1 are ignored.
- `rd_en` without a select produces no response.

## Timing
- Read latency is 1 cycle. An access at edge k gives `rd_valid`=1 and `rd_data` after edge k. The captured value is the state before edge k, so it includes the flags being cleared.
- Outside a valid cycle, `rd_data` returns to 0 and `rd_valid`=0.
- Back-to-back accesses are supported, one per cycle. Two consecutive key reads: the second returns flags = 0 unless a new press arrived.
- Input latency: a clean raw change becomes visible in stable DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
- `key_irq` follows `press_flag` with 1 cycle of register delay.
- Reset values (asynchronous):
  - synchronizers: switches 0, keys 1 (released)
  - stable: switches 0, keys 1
  - counters 0
  - `press_flag` 0
  - `rd_data` 0, `rd_valid` 0, `key_irq` 0
- Reset asserted mid-read drops the pending response. A key held through reset is not reported as a press until it is released and pressed again.

## Structure
- Shared package `dlx_io_pkg`:
  - address constants `IO_ADDR_SWITCHES`=0, `IO_ADDR_KEYS`=1, `IO_ADDR_LED`=2, `IO_ADDR_7SEG_LO`=3, `IO_ADDR_7SEG_HI`=7
  - `KEY_FLAG_LSB`=16
- Sub-module `io_debounce`: one bit, holds synchronizer + counter + stable, parameter DEBOUNCE_CYCLES, reset value as a parameter. Instantiated per bit with a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then read switches with `sw_in`=10'h2A5 held for 10 cycles → `rd_valid` pulse, `rd_data`=32'h000002A5. Before the debounce completes, the read returns 0.
- `key_n_in[1]` driven low for 3 cycles then high → `key_down` and flags never set; keys read = 32'h0.
- Key 2 held low for 8 cycles, then released → keys read during hold = 32'h00040004, `key_irq`=1. Read after release = 32'h0, `key_irq` back to 0 one cycle later.
- Press event landing in the same cycle as a keys read that clears flag 0 → the read returns the old flags; the next read returns flag 0 set.
- `rd_en` with no select, then `rd_en` with both selects → no `rd_valid`, then the switch word is returned.
- `rst_n` pulsed low during an accepted read → no `rd_valid`, all outputs 0 asynchronously. A key held through reset produces no flag.
